// File: rtl/sprite_anim_if.sv
// sprite_anim_if: button/hit inputs and sprite state outputs of one player's animation sequencer
interface sprite_anim_if;
  logic frame_tick;
  logic btn_fwd;
  logic btn_back;
  logic btn_atk;
  logic btn_dir;
  logic btn_block;
  logic hit_in;
  logic [3:0] currentstate;
  logic [9:0] posx;
  logic attack_active;
  logic hit_blocked;
  logic busy;
  modport master (
    output frame_tick, btn_fwd, btn_back, btn_atk, btn_dir, btn_block, hit_in,
    input currentstate, posx, attack_active, hit_blocked, busy
  );
  modport slave (
    input frame_tick, btn_fwd, btn_back, btn_atk, btn_dir, btn_block, hit_in,
    output currentstate, posx, attack_active, hit_blocked, busy
  );
endinterface

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: per-player sprite state sequencer; define ANIM_CANCEL_EN to let attack/dir buttons cancel pull phases
module sprite_anim_ctrl #(
  parameter int INIT_X      = 100,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 490,
  parameter int WALK_STEP   = 3,
  parameter bit FACE_LEFT   = 1'b0,
  parameter int ATK_START_F = 5,
  parameter int ATK_END_F   = 3,
  parameter int ATK_PULL_F  = 4,
  parameter int DIR_START_F = 4,
  parameter int DIR_END_F   = 3,
  parameter int DIR_PULL_F  = 5,
  parameter int HIT_F       = 12
) (
  input logic clk,
  input logic rst,
  sprite_anim_if.slave s
);
  typedef enum logic [3:0] {
    IDLE, WALK, WALKBACK, ATK_S, ATK_E, ATK_P, DIR_S, DIR_E, DIR_P, GOTHIT, BLOCK
  } state_t;
  state_t st, ns;
  logic [3:0] cnt, ncnt;
  logic [9:0] x, nx;
  logic [10:0] x_up, x_dn;
  logic hit_pending, fwd, aa, hb, bz;
  always_comb begin
    x_up = {1'b0, x} + 11'(WALK_STEP);
    x_dn = {1'b0, x} - 11'(WALK_STEP);
    fwd = (st == WALK) ^ FACE_LEFT;
    nx = x;
    if (st == WALK || st == WALKBACK)
      nx = fwd ? (x_up > 11'(X_MAX) ? 10'(X_MAX) : x_up[9:0])
               : ({1'b0, x} < 11'(X_MIN) + 11'(WALK_STEP) ? 10'(X_MIN) : x_dn[9:0]);
    ns = st;
    ncnt = cnt - 4'd1;
    if (hit_pending) begin
      ns = GOTHIT;
      ncnt = 4'(HIT_F);
    end else if (st == IDLE || st == WALK || st == WALKBACK || st == BLOCK) begin
      ns = s.btn_block ? BLOCK : s.btn_dir ? DIR_S : s.btn_atk ? ATK_S :
           (s.btn_fwd ^ s.btn_back) ? (s.btn_fwd ? WALK : WALKBACK) : IDLE;
      ncnt = s.btn_dir ? 4'(DIR_START_F) : 4'(ATK_START_F);
`ifdef ANIM_CANCEL_EN
    end else if ((st == ATK_P || st == DIR_P) && (s.btn_dir || s.btn_atk)) begin
      ns = s.btn_dir ? DIR_S : ATK_S;
      ncnt = s.btn_dir ? 4'(DIR_START_F) : 4'(ATK_START_F);
`endif
    end else if (cnt == 4'd1) begin
      ns = st == ATK_S ? ATK_E : st == ATK_E ? ATK_P : st == DIR_S ? DIR_E : st == DIR_E ? DIR_P : IDLE;
      ncnt = ns == ATK_E ? 4'(ATK_END_F) : ns == ATK_P ? 4'(ATK_PULL_F) :
             ns == DIR_E ? 4'(DIR_END_F) : 4'(DIR_PULL_F);
    end
  end
  // a pending hit always wins the next tick, so any tick consumes it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      x <= 10'(INIT_X);
      hit_pending <= 1'b0;
      aa <= 1'b0;
      hb <= 1'b0;
      bz <= 1'b0;
    end else begin
      hb <= s.hit_in && st == BLOCK;
      hit_pending <= (s.hit_in && st != BLOCK) || (hit_pending && !s.frame_tick);
      if (s.frame_tick) begin
        st <= ns;
        cnt <= ncnt;
        x <= nx;
        aa <= ns == ATK_E || ns == DIR_E;
        bz <= ns >= ATK_S && ns <= GOTHIT;
      end
    end
  assign s.currentstate = st;
  assign s.posx = x;
  assign s.attack_active = aa;
  assign s.hit_blocked = hb;
  assign s.busy = bz;
endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// tb_sprite_anim_ctrl: directed and random stimulus against a frame-level reference model
module tb_sprite_anim_ctrl;
`ifdef ANIM_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int m_st, m_left;
  int m_x[2];
  bit m_pend, m_hb;
  always #5 clk = ~clk;
  sprite_anim_if bif();
  sprite_anim_if sif();
  assign sif.frame_tick = bif.frame_tick;
  assign sif.btn_fwd = bif.btn_fwd;
  assign sif.btn_back = bif.btn_back;
  assign sif.btn_atk = bif.btn_atk;
  assign sif.btn_dir = bif.btn_dir;
  assign sif.btn_block = bif.btn_block;
  assign sif.hit_in = bif.hit_in;
  sprite_anim_ctrl u_dut (.clk(clk), .rst(rst), .s(bif.slave));
  sprite_anim_ctrl #(.INIT_X(488)) u_sat (.clk(clk), .rst(rst), .s(sif.slave));
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int dur(input int st);
    case (st)
      3: return 5;
      4: return 3;
      5: return 4;
      6: return 4;
      7: return 3;
      8: return 5;
      9: return 12;
      default: return 0;
    endcase
  endfunction
  function automatic int after(input int st);
    case (st)
      3: return 4;
      4: return 5;
      6: return 7;
      7: return 8;
      default: return 0;
    endcase
  endfunction
  task automatic model_tick(input logic [4:0] b);
    int step;
    for (int i = 0; i < 2; i++)
      if (m_st == 1 || m_st == 2) begin
        step = (m_st == 1) ? 3 : -3;
        m_x[i] = m_x[i] + step;
        if (m_x[i] > 490) m_x[i] = 490;
        if (m_x[i] < 0) m_x[i] = 0;
      end
    if (m_pend) begin
      m_st = 9;
      m_left = 12;
    end else if (m_st == 0 || m_st == 1 || m_st == 2 || m_st == 10) begin
      m_st = b[4] ? 10 : b[3] ? 6 : b[2] ? 3 : (b[0] && !b[1]) ? 1 : (b[1] && !b[0]) ? 2 : 0;
      m_left = dur(m_st);
    end else if (CANCEL && (m_st == 5 || m_st == 8) && (b[3] || b[2])) begin
      m_st = b[3] ? 6 : 3;
      m_left = dur(m_st);
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_st = after(m_st);
        m_left = dur(m_st);
      end
    end
  endtask
  task automatic compare();
    check("state", int'(bif.currentstate), m_st);
    check("posx", int'(bif.posx), m_x[0]);
    check("posx_sat", int'(sif.posx), m_x[1]);
    check("attack_active", int'(bif.attack_active), int'(m_st == 4 || m_st == 7));
    check("busy", int'(bif.busy), int'(m_st >= 3 && m_st <= 9));
    check("hit_blocked", int'(bif.hit_blocked), int'(m_hb));
  endtask
  // b = {block, dir, atk, back, fwd}
  task automatic cycle(input bit tick, input logic [4:0] b, input bit hit);
    bit np;
    @(negedge clk);
    bif.frame_tick = tick;
    {bif.btn_block, bif.btn_dir, bif.btn_atk, bif.btn_back, bif.btn_fwd} = b;
    bif.hit_in = hit;
    @(posedge clk);
    m_hb = hit && m_st == 10;
    np = (hit && m_st != 10) || (m_pend && !tick);
    if (tick) model_tick(b);
    m_pend = np;
    #1 compare();
  endtask
  task automatic tick(input logic [4:0] b);
    cycle(1'b0, b, 1'b0);
    cycle(1'b0, b, 1'b0);
    cycle(1'b1, b, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    {bif.frame_tick, bif.btn_block, bif.btn_dir, bif.btn_atk, bif.btn_back, bif.btn_fwd, bif.hit_in} = '0;
    m_st = 0;
    m_left = 0;
    m_x[0] = 100;
    m_x[1] = 488;
    m_pend = 1'b0;
    m_hb = 1'b0;
    #1 compare();
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    check("rst_state", int'(bif.currentstate), 0);
    check("rst_posx", int'(bif.posx), 100);
    repeat (3) tick(5'b0);
    check("idle_busy", int'(bif.busy), 0);
    repeat (10) tick(5'b00001);
    check("walk10_posx", int'(bif.posx), 127);
    do_reset();
    repeat (5) tick(5'b00001);
    check("sat_posx", int'(sif.posx), 490);
    do_reset();
    tick(5'b00100);
    check("atk_T", int'(bif.currentstate), 3);
    for (int k = 1; k <= 12; k++) begin
      tick(5'b0);
      check("atk_seq", int'(bif.currentstate), k < 5 ? 3 : k < 8 ? 4 : k < 12 ? 5 : 0);
      check("atk_live", int'(bif.attack_active), int'(k >= 5 && k < 8));
    end
    do_reset();
    tick(5'b10000);
    cycle(1'b0, 5'b10000, 1'b1);
    check("blk_pulse", int'(bif.hit_blocked), 1);
    cycle(1'b0, 5'b10000, 1'b0);
    check("blk_pulse_end", int'(bif.hit_blocked), 0);
    tick(5'b10000);
    check("blk_hold", int'(bif.currentstate), 10);
    do_reset();
    repeat (6) tick(5'b00100);
    check("in_atkend", int'(bif.currentstate), 4);
    cycle(1'b0, 5'b0, 1'b1);
    tick(5'b0);
    check("abort_hit", int'(bif.currentstate), 9);
    for (int k = 1; k <= 12; k++) begin
      tick(5'b0);
      check("stun", int'(bif.currentstate), k < 12 ? 9 : 0);
    end
    tick(5'b00011);
    check("fwd_back", int'(bif.currentstate), 0);
    check("fwd_back_x", int'(bif.posx), 100);
    tick(5'b10100);
    check("blk_atk", int'(bif.currentstate), 10);
    do_reset();
    tick(5'b00100);
    repeat (8) tick(5'b0);
    check("pull_entry", int'(bif.currentstate), 5);
    tick(5'b01000);
    check("pull_2nd", int'(bif.currentstate), CANCEL ? 6 : 5);
    repeat (3) tick(5'b0);
    if (!CANCEL) check("pull_done", int'(bif.currentstate), 0);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] b;
      b = 5'($urandom);
      b[4] = $urandom_range(7) == 0;
      cycle($urandom_range(3) == 0, b, $urandom_range(15) == 0);
      if ($urandom_range(999) == 0) do_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_anim_ctrl.md
Name: sprite_anim_ctrl

Overview:
- Per-player animation sequencer. Converts button levels and hit events into the 4-bit sprite state code (0..10) and horizontal position consumed by the sprite ROM renderer.
- Sequences timed attack phases (start → end → pull), hit-stun and block.
- All animation timing advances on the frame tick.
- Instantiated once per player; player 2 uses FACE_LEFT=1.

Parameters:
- INIT_X, 100, posx value loaded on reset.
- X_MIN, 0, lowest legal posx.
- X_MAX, 490, highest legal posx (640 − 150 sprite width).
- WALK_STEP, 3, pixels moved per frame while walking.
- FACE_LEFT, 0, when 1, "forward" decrements posx.
- ATK_START_F, 5, frames spent in attackstart.
- ATK_END_F, 3, frames spent in attackend.
- ATK_PULL_F, 4, frames spent in attackpull.
- DIR_START_F, 4, frames spent in dirattstart.
- DIR_END_F, 3, frames spent in dirattend.
- DIR_PULL_F, 5, frames spent in dirattpull.
- HIT_F, 12, frames spent in gothit.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- btn_fwd  in  1  level, move forward
- btn_back  in  1  level, move backward
- btn_atk  in  1  level, basic attack
- btn_dir  in  1  level, directional attack
- btn_block  in  1  level, block
- hit_in  in  1  one-cycle pulse, opponent hitbox connected
- currentstate  out  4  sprite state code
- posx  out  10  player X position
- attack_active  out  1  hitbox live
- hit_blocked  out  1  one-cycle pulse, hit absorbed by block
- busy  out  1  in a non-interruptible animation

Behaviour:
- Reset values:
  - currentstate=0 (idle), posx=INIT_X, attack_active=0, hit_blocked=0, busy=0.
  - frame counter=0, hit_pending=0.
- State codes: 0 idle, 1 walk, 2 walkback, 3 attackstart, 4 attackend, 5 attackpull, 6 dirattstart, 7 dirattend, 8 dirattpull, 9 gothit, 10 block. Codes 11–15 are never produced.
- hit_in handling:
  - Sampled every clk.
  - If currentstate==10: hit_blocked pulses high the next cycle and no pending hit is recorded.
  - Otherwise hit_pending is set.
  - hit_pending is cleared on the frame_tick that enters gothit.
- State/counter update: only on cycles with frame_tick=1. Between ticks, currentstate and posx hold.
- Idle/walk/walkback/block decision (per tick), priority order:
  1. hit_pending → 9.
  2. btn_block → 10.
  3. btn_dir → 6.
  4. btn_atk → 3.
  5. btn_fwd xor btn_back → 1 (fwd) or 2 (back).
  6. Otherwise → 0.
  - Block is held while btn_block is high. On release, the next tick re-evaluates the list above.
- Timed states:
  - The counter loads the state's frame count on entry and decrements each tick.
  - When the counter reads 1 on a tick, the state advances: 3→4→5→0 and 6→7→8→0.
  - Exit tick = entry tick + N.
- gothit: lasts HIT_F ticks, then → 0.
  - hit_pending during gothit re-arms the counter to HIT_F (restarts the stun).
  - hit_pending during any attack state aborts the attack → 9 on the next tick.
- Movement:
  - On each tick in state 1, posx moves WALK_STEP forward; in state 2, WALK_STEP backward. Direction is inverted when FACE_LEFT=1.
  - posx saturates at X_MIN/X_MAX. Use an 11-bit intermediate so there is no wrap.
  - Movement is applied on the same tick that is in state 1/2. No movement on the entry tick.
- attack_active = (currentstate==4 || currentstate==7), registered with the state.
- busy = 1 in states 3–9.
- Reset asserted mid-animation returns immediately to the reset values.

Optional Feature:
- Macro: ANIM_CANCEL_EN.
- Defined: in state 5 or 8, a tick with btn_atk=1 → 3, or btn_dir=1 → 6 (btn_dir has priority). The cancel is taken only after at least one pull frame has elapsed.
- Undefined: pull phases always run to completion. Buttons are ignored in states 3–9.

Test Plan:
- Reset, then 3 ticks with no buttons → currentstate=0, posx=100, busy=0.
- btn_fwd held for 10 ticks, FACE_LEFT=0 → posx=127. With INIT_X=488 and 5 ticks → posx=490 (saturates).
- btn_atk pulse before tick T → states 3 at T, 4 at T+5, 5 at T+8, 0 at T+12. attack_active high exactly during ticks T+5..T+7.
- In state 10, hit_in pulse → hit_blocked high exactly 1 cycle, state stays 10. In state 4, hit_in → 9 at the next tick, then 0 after 12 ticks.
- btn_fwd and btn_back both held → state 0, posx unchanged. btn_block and btn_atk together → state 10.
- With ANIM_CANCEL_EN defined, btn_dir held at the 2nd tick of attackpull → 6. With the macro undefined, the pull completes and the state goes to 0.
